// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Main controller for a multicycle MIPS datapath. It is a Moore FSM that
//   sequences FETCH / DECODE / EXEC / MEM / WB for each instruction. It
//   drives aluop to the downstream ALU decoder, plus all datapath enables
//   and selects. Memory states stall on mem_ready. If memory does not
//   answer within TIMEOUT cycles, the access is aborted back to FETCH.
//
// Parameters
//   TIMEOUT      max cycles spent waiting on mem_ready in one memory state
//                (>= 2)
// Configuration macro
//   MC_CTRL_BNE_EN  when defined, adds bne (op 000101) as a branch-on-not-
//                   zero state. When undefined, that opcode is illegal.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low
//   op[5:0]      in   opcode from the instruction register
//   zero         in   ALU zero flag
//   mem_ready    in   memory ack; the access completes in the cycle it is 1
//   mem_req      out  memory access request (FETCH, MEMRD, MEMWR)
//   memwrite     out  store strobe
//   irwrite      out  instruction register load
//   pcwrite      out  PC load
//   iord         out  0 = PC address, 1 = ALUOut address
//   alusrca      out  0 = PC, 1 = regA
//   alusrcb[1:0] out  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//   aluop[1:0]   out  00 add, 01 sub, 10 funct-decoded
//   pcsrc[1:0]   out  00 ALU result, 01 ALUOut, 10 jump target
//   regwrite     out  register file write enable
//   regdst       out  0 = rt, 1 = rd
//   memtoreg     out  0 = ALUOut, 1 = memory data
//   illegal_op   out  1-cycle pulse on an unknown opcode
//   mem_timeout  out  1-cycle pulse on a stall abort
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ill_q, ill_nxt;
  logic          is_mem, timeout;

  // Stall bookkeeping shared by the next-state and output logic.
  assign is_mem  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout = is_mem && !mem_ready && (cnt == LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ill_q <= ill_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ill_nxt   = 1'b0;
    // The counter only keeps counting while we stay in the same memory
    // state. Any other path, including a timeout re-entry into FETCH,
    // starts the next memory state from zero.
    cnt_nxt   = (is_mem && !mem_ready && !timeout) ? cnt + 1'b1 : '0;
    unique case (state)
      FETCH:   if (timeout) state_nxt = FETCH;
               else if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_nxt = BNEEX;
`endif
          default: begin
            state_nxt = FETCH;
            ill_nxt   = 1'b1;
          end
        endcase
      end
      MEMADR:  state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (timeout) state_nxt = FETCH;
               else if (mem_ready) state_nxt = MEMWB;
      MEMWR:   if (timeout || mem_ready) state_nxt = FETCH;
      MEMWB:   state_nxt = FETCH;
      RTYPEEX: state_nxt = RTYPEWB;
      RTYPEWB: state_nxt = FETCH;
      BEQEX:   state_nxt = FETCH;
      BNEEX:   state_nxt = FETCH;
      ADDIEX:  state_nxt = ADDIWB;
      ADDIWB:  state_nxt = FETCH;
      JEX:     state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Output logic. The illegal-opcode pulse is registered. Because of that,
  // op never reaches an output combinationally, and the pulse appears in
  // the cycle right after DECODE. Everything is forced low while reset is
  // held, so no strobe can fire in the reset cycle.
  always_comb begin
    mem_req     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsrc       = 2'b00;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (reset) begin
      illegal_op  = ill_q;
      mem_timeout = timeout;
      unique case (state)
        FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        DECODE:  alusrcb = 2'b11;
        MEMADR, ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = mem_ready;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        RTYPEWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        BEQEX, BNEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          pcwrite = (state == BEQEX) ? zero : ~zero;
        end
        ADDIWB:  regwrite = 1'b1;
        JEX: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Directed bench for mc_control_fsm (TIMEOUT = 16). Each step does three
//   things: it drives the inputs shortly after a falling edge, compares the
//   packed output vector against a hand-built constant, and then advances
//   one clock.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, irwrite, pcwrite, iord, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       regwrite, regdst, memtoreg, illegal_op, mem_timeout;

  int total = 0;
  int bad   = 0;

  mc_control_fsm #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite),
    .pcwrite(pcwrite), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Packed output vector, MSB first:
  // mem_req memwrite irwrite pcwrite iord alusrca alusrcb aluop pcsrc
  // regwrite regdst memtoreg illegal_op mem_timeout
  logic [16:0] outv;
  assign outv = {mem_req, memwrite, irwrite, pcwrite, iord, alusrca,
                 alusrcb, aluop, pcsrc, regwrite, regdst, memtoreg,
                 illegal_op, mem_timeout};

  localparam logic [16:0] E_ZERO     = 17'b0_0_0_0_0_0_00_00_00_0_0_0_0_0;
  localparam logic [16:0] E_FWAIT    = 17'b1_0_0_0_0_0_01_00_00_0_0_0_0_0;
  localparam logic [16:0] E_FGO      = 17'b1_0_1_1_0_0_01_00_00_0_0_0_0_0;
  localparam logic [16:0] E_FWAIT_IL = 17'b1_0_0_0_0_0_01_00_00_0_0_0_1_0;
  localparam logic [16:0] E_FGO_IL   = 17'b1_0_1_1_0_0_01_00_00_0_0_0_1_0;
  localparam logic [16:0] E_FTO      = 17'b1_0_0_0_0_0_01_00_00_0_0_0_0_1;
  localparam logic [16:0] E_DECODE   = 17'b0_0_0_0_0_0_11_00_00_0_0_0_0_0;
  localparam logic [16:0] E_MEMADR   = 17'b0_0_0_0_0_1_10_00_00_0_0_0_0_0;
  localparam logic [16:0] E_MEMRD    = 17'b1_0_0_0_1_0_00_00_00_0_0_0_0_0;
  localparam logic [16:0] E_MEMWB    = 17'b0_0_0_0_0_0_00_00_00_1_0_1_0_0;
  localparam logic [16:0] E_MWR_WAIT = 17'b1_0_0_0_1_0_00_00_00_0_0_0_0_0;
  localparam logic [16:0] E_MWR_GO   = 17'b1_1_0_0_1_0_00_00_00_0_0_0_0_0;
  localparam logic [16:0] E_RTEX     = 17'b0_0_0_0_0_1_00_10_00_0_0_0_0_0;
  localparam logic [16:0] E_RTWB     = 17'b0_0_0_0_0_0_00_00_00_1_1_0_0_0;
  localparam logic [16:0] E_BR_T     = 17'b0_0_0_1_0_1_00_01_01_0_0_0_0_0;
  localparam logic [16:0] E_BR_N     = 17'b0_0_0_0_0_1_00_01_01_0_0_0_0_0;
  localparam logic [16:0] E_ADDIWB   = 17'b0_0_0_0_0_0_00_00_00_1_0_0_0_0;
  localparam logic [16:0] E_JEX      = 17'b0_0_0_1_0_0_00_00_10_0_0_0_0_0;

  task automatic step(input string tag, input logic r, input logic [5:0] o,
                      input logic z, input logic mr, input logic [16:0] exp);
    reset = r; op = o; zero = z; mem_ready = mr;
    #1;
    total++;
    assert (outv === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, outv, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    // Power-on reset: every output stays low
    step("rst0", 0, 6'b000000, 0, 1, E_ZERO);
    step("rst1", 0, 6'b000000, 0, 1, E_ZERO);

    // R-type, 4 cycles. op changes after DECODE have no effect
    step("rt_fetch",  1, 6'b000000, 0, 1, E_FGO);
    step("rt_decode", 1, 6'b000000, 0, 1, E_DECODE);
    step("rt_ex",     1, 6'b100011, 0, 1, E_RTEX);
    step("rt_wb",     1, 6'b100011, 0, 1, E_RTWB);

    // lw with 3 stall cycles in MEMRD: 8 cycles in total
    step("lw_fetch",  1, 6'b100011, 0, 1, E_FGO);
    step("lw_decode", 1, 6'b100011, 0, 1, E_DECODE);
    step("lw_adr",    1, 6'b100011, 0, 1, E_MEMADR);
    step("lw_stall0", 1, 6'b100011, 0, 0, E_MEMRD);
    step("lw_stall1", 1, 6'b100011, 0, 0, E_MEMRD);
    step("lw_stall2", 1, 6'b100011, 0, 0, E_MEMRD);
    step("lw_rd",     1, 6'b100011, 0, 1, E_MEMRD);
    step("lw_wb",     1, 6'b100011, 0, 1, E_MEMWB);

    // sw with one stall cycle; memwrite follows mem_ready
    step("sw_fetch",  1, 6'b101011, 0, 1, E_FGO);
    step("sw_decode", 1, 6'b101011, 0, 1, E_DECODE);
    step("sw_adr",    1, 6'b101011, 0, 1, E_MEMADR);
    step("sw_wait",   1, 6'b101011, 0, 0, E_MWR_WAIT);
    step("sw_wr",     1, 6'b101011, 0, 1, E_MWR_GO);

    // beq taken, then beq not taken
    step("beq1_fetch",  1, 6'b000100, 1, 1, E_FGO);
    step("beq1_decode", 1, 6'b000100, 1, 1, E_DECODE);
    step("beq1_ex",     1, 6'b000100, 1, 1, E_BR_T);
    step("beq0_fetch",  1, 6'b000100, 0, 1, E_FGO);
    step("beq0_decode", 1, 6'b000100, 0, 1, E_DECODE);
    step("beq0_ex",     1, 6'b000100, 0, 1, E_BR_N);

    // addi, then j
    step("addi_fetch",  1, 6'b001000, 0, 1, E_FGO);
    step("addi_decode", 1, 6'b001000, 0, 1, E_DECODE);
    step("addi_ex",     1, 6'b001000, 0, 1, E_MEMADR);
    step("addi_wb",     1, 6'b001000, 0, 1, E_ADDIWB);
    step("j_fetch",     1, 6'b000010, 0, 1, E_FGO);
    step("j_decode",    1, 6'b000010, 0, 1, E_DECODE);
    step("j_ex",        1, 6'b000010, 0, 1, E_JEX);

    // bne with zero=0: taken branch if enabled, otherwise an illegal opcode
    step("bne_fetch",  1, 6'b000101, 0, 1, E_FGO);
    step("bne_decode", 1, 6'b000101, 0, 1, E_DECODE);
`ifdef MC_CTRL_BNE_EN
    step("bne_ex",     1, 6'b000101, 0, 1, E_BR_T);
    step("bne_refetch", 1, 6'b000000, 0, 1, E_FGO);
`else
    step("bne_illegal", 1, 6'b000000, 0, 1, E_FGO_IL);
`endif
    step("bne_next_decode", 1, 6'b000000, 0, 1, E_DECODE);
    step("bne_next_rtex",   1, 6'b000000, 0, 1, E_RTEX);
    step("bne_next_rtwb",   1, 6'b000000, 0, 1, E_RTWB);

    // Illegal opcode, then FETCH starved of mem_ready -> timeout at count 15
    step("ill_fetch",  1, 6'b111111, 0, 1, E_FGO);
    step("ill_decode", 1, 6'b111111, 0, 1, E_DECODE);
    step("ill_pulse",  1, 6'b111111, 0, 0, E_FWAIT_IL);   // stall count 0
    for (int i = 1; i < 15; i++) step("to_wait", 1, 6'b111111, 0, 0, E_FWAIT);
    step("to_pulse",   1, 6'b111111, 0, 0, E_FTO);        // count 15
    step("to_restart", 1, 6'b111111, 0, 0, E_FWAIT);      // count 0 again

    // mem_ready arriving exactly at the limit wins over the timeout
    for (int i = 1; i < 15; i++) step("lim_wait", 1, 6'b111111, 0, 0, E_FWAIT);
    step("lim_win",    1, 6'b111111, 0, 1, E_FGO);
    step("lim_decode", 1, 6'b100011, 0, 1, E_DECODE);

    // Reset in the middle of MEMRD aborts to FETCH with no strobes
    step("rmid_adr",   1, 6'b100011, 0, 1, E_MEMADR);
    step("rmid_memrd", 1, 6'b100011, 0, 0, E_MEMRD);
    step("rmid_rst0",  0, 6'b100011, 0, 1, E_ZERO);
    step("rmid_rst1",  0, 6'b100011, 0, 1, E_ZERO);
    step("rmid_fetch", 1, 6'b100011, 0, 0, E_FWAIT);
    step("rmid_go",    1, 6'b100011, 0, 1, E_FGO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
